rca_chunked_adder: RTL and testbench
====================================

RCA_CHUNKED_ADDER -- requirements
Module: rca_chunked_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port i_clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-005 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port i_valid, input, 1 bit: an operand set is offered.
REQ-007 Port o_ready, output, 1 bit: the block can accept an operand set.
REQ-008 Port i_add_term1, input, WIDTH bits: operand A.
REQ-009 Port i_add_term2, input, WIDTH bits: operand B.
REQ-010 Port i_carry, input, 1 bit: carry-in, used in add mode only.
REQ-011 Port i_sub, input, 1 bit: 1 selects A-B, 0 selects A+B+i_carry.
REQ-012 Port o_valid, output, 1 bit: o_result and o_overflow are valid.
REQ-013 Port i_ready, input, 1 bit: the consumer accepts the result.
REQ-014 Port o_result, output, WIDTH+1 bits: {carry-out, sum}.
REQ-015 Port o_overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-017 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-018 In IDLE, i_valid=1 SHALL capture A, B (inverted when i_sub=1), the carry seed (1 when i_sub=1, else i_carry) and the mode; it SHALL clear the chunk counter and enter BUSY.
REQ-019 In IDLE, i_valid=0 SHALL hold all state.
REQ-020 Each BUSY cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) with the registered carry, store the chunk sum and carry-out, and increment k.
REQ-021 After chunk NCHUNK-1 is processed, the FSM SHALL enter DONE; o_valid SHALL therefore rise exactly NCHUNK cycles after the accepting edge.
REQ-022 o_result[WIDTH] SHALL be the final carry-out; in subtract mode it is the not-borrow flag (1 when A >= B unsigned).
REQ-023 o_overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-024 In DONE, o_result and o_overflow SHALL stay stable while i_ready=0, and i_valid SHALL be ignored.
REQ-025 DONE with i_ready=1 SHALL return to IDLE; o_ready SHALL not rise in that same cycle, so there is no back-to-back accept.
REQ-026 Sustained throughput SHALL be one operation per NCHUNK+2 cycles.
REQ-027 Wrap-around: A+B SHALL be taken modulo 2^(WIDTH+1) in o_result, with no saturation.
REQ-028 The case CHUNK=WIDTH SHALL be legal and SHALL give 1-cycle BUSY latency.
REQ-029 Operand, mode and carry inputs SHALL be sampled only on the accepting edge.

Reset
REQ-030 When i_rst=1 on a rising edge, the FSM SHALL go to IDLE, o_ready SHALL become 1, and o_valid, o_result, o_overflow, the chunk counter and all operand registers SHALL become 0.
REQ-031 Reset SHALL take priority over all other events, aborting any BUSY or DONE transaction with no output produced.
REQ-032 The first cycle after reset deasserts SHALL accept i_valid.

Structure
REQ-033 Package rca_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and a function computing counter width as clog2(NCHUNK), minimum 1.
REQ-034 One sub-module, rca_chunk, SHALL implement the combinational CHUNK-bit ripple-carry adder built from the existing full_adder cell, with a carry-in, a carry-out and an MSB carry-in output for overflow.
REQ-035 The top level SHALL hold only the FSM, counter, registers and handshake.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-036 Add 0xFFFFFFFF + 0x00000001, i_carry=0 -> o_result=0x1_00000000, o_overflow=0, o_valid 4 cycles after the accept.
REQ-037 Add 0x7FFFFFFF + 0x00000001 -> o_result=0x0_80000000, o_overflow=1; 0x80000000 + 0x80000000 -> 0x1_00000000, o_overflow=1.
REQ-038 Subtract 5 - 7 -> o_result=0x0_FFFFFFFE, o_overflow=0; subtract 7 - 5 -> 0x1_00000002.
REQ-039 Backpressure: hold i_ready=0 for 3 cycles in DONE while driving i_valid=1 with new operands -> o_result unchanged, o_ready=0, and the new operands are not captured; o_ready=1 the cycle after the i_ready=1 handshake.
REQ-040 Assert i_rst after 2 BUSY cycles -> next cycle IDLE, o_valid=0, o_result=0, and a following add of 3+4 returns 0x0_00000007.
REQ-041 WIDTH=6, CHUNK=6: 63 + 63, i_carry=1 -> o_result=127, o_valid 1 cycle after the accept; an exhaustive sweep over WIDTH=6, CHUNK=3 matches a reference model.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the chunked ripple-carry adder.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rca_state_t;

  // Chunk counter width: clog2 of the chunk count, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    if (nchunk <= 1) return 1;
    return $clog2(nchunk);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
// Also exposes the carry into its MSB so the caller can form signed overflow.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_msb_cin
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    full_adder u_fa (
      .i_a   (i_a[g]),
      .i_b   (i_b[g]),
      .i_cin (w_c[g]),
      .o_sum (o_sum[g]),
      .o_cout(w_c[g+1])
    );
  end

  assign o_cout    = w_c[CHUNK];
  assign o_msb_cin = w_c[CHUNK-1];

endmodule

// File: rtl/rca_chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle through a shared
// ripple-carry chunk, with a valid/ready handshake on both sides.
module rca_chunked_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);

  rca_state_t       r_state;
  rca_state_t       w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic [CW-1:0]    r_k;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_cs;
  logic             w_cout;
  logic             w_msb_cin;

  assign w_last = (r_k == CW'(NCHUNK - 1));

  // State register; reset overrides any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next   = r_state;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    w_accept = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Select the operand slices for the chunk currently being added.
  always_comb begin
    w_ca = '0;
    w_cb = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (r_k == CW'(i)) begin
        w_ca = r_a[i*CHUNK +: CHUNK];
        w_cb = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .i_a      (w_ca),
    .i_b      (w_cb),
    .i_cin    (r_carry),
    .o_sum    (w_cs),
    .o_cout   (w_cout),
    .o_msb_cin(w_msb_cin)
  );

  // Operand capture and per-chunk accumulation.
  // Subtract mode is folded into the captured operands (inverted B, carry seed 1),
  // so no separate mode bit is needed once the operation is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= i_add_term1;
      r_b     <= i_sub ? ~i_add_term2 : i_add_term2;
      r_carry <= i_sub | i_carry;
      r_k     <= '0;
    end else if (w_step) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (r_k == CW'(i)) r_sum[i*CHUNK +: CHUNK] <= w_cs;
      end
      r_carry <= w_cout;
      if (w_last) r_ovf <= w_msb_cin ^ w_cout;
      else        r_k   <= r_k + 1'b1;
    end
  end

  assign o_result   = {r_carry, r_sum};
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_rca_chunked_adder.sv
// Self-checking bench: three adder configurations (32/8, 6/6, 6/3) driven
// through one shared stimulus path selected by 'sel'.
module tb_rca_chunked_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  int          sel = 0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        op_cin = 1'b0;
  logic        op_sub = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  logic        v0, v1, v2, r0, r1, r2;
  logic        rdy0, rdy1, rdy2, val0, val1, val2, ovf0, ovf1, ovf2;
  logic [32:0] res0;
  logic [6:0]  res1, res2;

  assign v0 = drv_valid && (sel == 0);
  assign v1 = drv_valid && (sel == 1);
  assign v2 = drv_valid && (sel == 2);
  assign r0 = drv_ready && (sel == 0);
  assign r1 = drv_ready && (sel == 1);
  assign r2 = drv_ready && (sel == 2);

  rca_chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(rdy0),
    .i_add_term1(op_a), .i_add_term2(op_b), .i_carry(op_cin), .i_sub(op_sub),
    .o_valid(val0), .i_ready(r0), .o_result(res0), .o_overflow(ovf0)
  );

  rca_chunked_adder #(.WIDTH(6), .CHUNK(6)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(rdy1),
    .i_add_term1(op_a[5:0]), .i_add_term2(op_b[5:0]), .i_carry(op_cin), .i_sub(op_sub),
    .o_valid(val1), .i_ready(r1), .o_result(res1), .o_overflow(ovf1)
  );

  rca_chunked_adder #(.WIDTH(6), .CHUNK(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2),
    .i_add_term1(op_a[5:0]), .i_add_term2(op_b[5:0]), .i_carry(op_cin), .i_sub(op_sub),
    .o_valid(val2), .i_ready(r2), .o_result(res2), .o_overflow(ovf2)
  );

  logic        obs_ready, obs_valid, obs_ovf;
  logic [32:0] obs_res;

  // Observation mux for the currently selected instance.
  always_comb begin
    obs_ready = rdy0;
    obs_valid = val0;
    obs_ovf   = ovf0;
    obs_res   = res0;
    if (sel == 1) begin
      obs_ready = rdy1; obs_valid = val1; obs_ovf = ovf1; obs_res = {26'd0, res1};
    end else if (sel == 2) begin
      obs_ready = rdy2; obs_valid = val2; obs_ovf = ovf2; obs_res = {26'd0, res2};
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d a=%0h b=%0h sub=%0b cin=%0b)",
               tag, obs, exp, sel, op_a, op_b, op_sub, op_cin);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 32 : 6;
  endfunction

  function automatic int nchunk_of(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 1 : 2);
  endfunction

  function automatic longint sx(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  task automatic ref_model(input int s, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub,
                           output logic [32:0] er, output logic eo);
    int          w;
    logic [63:0] m, av, bv, t;
    longint      sv, hi, lo;
    w  = width_of(s);
    m  = (64'd1 << w) - 64'd1;
    av = {32'd0, a} & m;
    bv = {32'd0, b} & m;
    if (!sub) begin
      t  = av + bv + {63'd0, cin};
      sv = sx(av, w) + sx(bv, w) + longint'(cin);
    end else begin
      t  = ((av >= bv) ? (64'd1 << w) : 64'd0) | ((av - bv) & m);
      sv = sx(av, w) - sx(bv, w);
    end
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    eo = (sv > hi) || (sv < lo);
    er = t[32:0];
  endtask

  // One full transaction on instance s; 'hold' DONE cycles with i_ready=0
  // while junk operands are offered.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input int hold,
                        output logic [32:0] got_res, output logic got_ovf);
    logic [32:0] er;
    logic        eo;
    int          waited, lat;
    sel = s;
    ref_model(s, a, b, cin, sub, er, eo);
    waited = 0;
    while (!obs_ready && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    got_res = '0;
    got_ovf = 1'b0;
    if (!obs_ready) begin
      chk_eq("ready_timeout", 64'(obs_ready), 64'd1);
      return;
    end
    op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_cin = 1'($urandom); op_sub = 1'($urandom);
    lat = 0;
    while (!obs_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk_eq("latency", 64'(lat), 64'(nchunk_of(s)));
    if (!obs_valid) return;
    got_res = obs_res;
    got_ovf = obs_ovf;
    chk_eq("result", 64'(obs_res), 64'(er));
    chk_eq("overflow", 64'(obs_ovf), 64'(eo));
    for (int h = 0; h < hold; h++) begin
      drv_valid = 1'b1;
      op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom);
      @(posedge clk); #1;
      chk_eq("hold_result", 64'(obs_res), 64'(er));
      chk_eq("hold_ovf", 64'(obs_ovf), 64'(eo));
      chk_eq("hold_ready", 64'(obs_ready), 64'd0);
      chk_eq("hold_valid", 64'(obs_valid), 64'd1);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    chk_eq("post_ready", 64'(obs_ready), 64'd1);
    chk_eq("post_valid", 64'(obs_valid), 64'd0);
  endtask

  initial begin
    logic [32:0] gr;
    logic        go;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    sel = 0;
    chk_eq("rst_ready", 64'(rdy0), 64'd1);
    chk_eq("rst_valid", 64'(val0), 64'd0);
    chk_eq("rst_result", 64'(res0), 64'd0);
    chk_eq("rst_ovf", 64'(ovf0), 64'd0);
    rst = 1'b0;

    // Directed corner cases, 32-bit / 8-bit chunks (first op right after reset).
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, gr, go);
    chk_eq("d_ffff_p1", 64'(gr), 64'h1_0000_0000);
    chk_eq("d_ffff_p1_ov", 64'(go), 64'd0);
    run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, gr, go);
    chk_eq("d_7fff_p1", 64'(gr), 64'h0_8000_0000);
    chk_eq("d_7fff_p1_ov", 64'(go), 64'd1);
    run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, gr, go);
    chk_eq("d_8000x2", 64'(gr), 64'h1_0000_0000);
    chk_eq("d_8000x2_ov", 64'(go), 64'd1);
    run_op(0, 32'd5, 32'd7, 1'b1, 1'b1, 0, gr, go);
    chk_eq("d_5m7", 64'(gr), 64'h0_FFFF_FFFE);
    chk_eq("d_5m7_ov", 64'(go), 64'd0);
    run_op(0, 32'd7, 32'd5, 1'b0, 1'b1, 0, gr, go);
    chk_eq("d_7m5", 64'(gr), 64'h1_0000_0002);

    // Backpressure with operands offered during DONE.
    run_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 3, gr, go);
    chk_eq("d_bp", 64'(gr), 64'h0_2222_2222);

    // Reset aborts a transaction after two BUSY cycles.
    sel = 0;
    op_a = 32'hDEAD_BEEF; op_b = 32'h1111_1111; op_cin = 1'b0; op_sub = 1'b0;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("abort_ready", 64'(rdy0), 64'd1);
    chk_eq("abort_valid", 64'(val0), 64'd0);
    chk_eq("abort_result", 64'(res0), 64'd0);
    chk_eq("abort_ovf", 64'(ovf0), 64'd0);
    run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0, gr, go);
    chk_eq("d_3p4", 64'(gr), 64'h0_0000_0007);

    // Randomized 32-bit traffic with occasional edge operands.
    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h0;
      run_op(0, ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 2), gr, go);
    end

    // Single-chunk configuration.
    run_op(1, 32'd63, 32'd63, 1'b1, 1'b0, 0, gr, go);
    chk_eq("d_63p63c", 64'(gr), 64'd127);
    for (int n = 0; n < 40; n++)
      run_op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 1), gr, go);

    // Exhaustive 6-bit sweep with 3-bit chunks: add, add+carry, subtract.
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++)
        for (int m = 0; m < 3; m++)
          run_op(2, 32'(a), 32'(b), (m == 1), (m == 2), 0, gr, go);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
